// File: rtl/ram_param.sv
// ram_param: single-port RAM with combinational read and a clear sequencer.
// After reset it zeroes every word, one per cycle, with busy held high.
// Reads return 0 and writes are ignored while busy or when the address is
// out of range.
// Optional build macro RAM_PARAM_PARITY_EN adds one even-parity bit per word,
// an err_inject write input and a sticky parity_err output.
module ram_param #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  out,
  output logic              busy
`ifdef RAM_PARAM_PARITY_EN
  ,
  input  logic              err_inject,
  output logic              parity_err
`endif
);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic in_range, clr_en, wr_en;

  // Range check is done in 32 bits so DEPTH that is not a power of two works.
  assign in_range = (32'(address) < 32'(DEPTH));
  assign busy     = reset || (state_q == CLEAR);
  assign clr_en   = !reset && (state_q == CLEAR);
  assign wr_en    = load && !busy && in_range;

  // Sequencer next state: walk clr_cnt through every word, then idle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST) state_d = IDLE;
    end
  end

  // Sequencer registers; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage: clear has priority, user writes only when idle and in range.
  always_ff @(posedge clk) begin
    if (clr_en)     mem_q[clr_cnt_q] <= '0;
    else if (wr_en) mem_q[address]   <= in;
  end

  // Combinational read, forced to 0 while busy or out of range.
  always_comb begin
    out = '0;
    if (!busy && in_range) out = mem_q[address];
  end

`ifdef RAM_PARAM_PARITY_EN
  logic par_q [DEPTH];
  logic parity_err_q;

  // Parity storage: even parity of the word, optionally inverted on write.
  always_ff @(posedge clk) begin
    if (clr_en)     par_q[clr_cnt_q] <= 1'b0;
    else if (wr_en) par_q[address]   <= (^in) ^ err_inject;
  end

  // Sticky error on any idle in-range access whose stored parity disagrees.
  always_ff @(posedge clk) begin
    if (reset)
      parity_err_q <= 1'b0;
    else if (!busy && in_range && ((^mem_q[address]) ^ par_q[address]))
      parity_err_q <= 1'b1;
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: default instance (DEPTH=16384) plus a
// DEPTH=12000 instance sharing the same stimulus for out-of-range checks.
module tb_ram_param;

  logic        gclk = 1'b0;
  logic        reset;
  logic [13:0] address;
  logic        load;
  logic [15:0] in;
  logic        err_inject;
  logic [15:0] out16, out12;
  logic        busy16, busy12;
`ifdef RAM_PARAM_PARITY_EN
  logic        perr16, perr12;
`endif

  always #5 gclk = ~gclk;

  ram_param u_dut16 (
    .clk(gclk), .reset(reset), .address(address), .load(load), .in(in),
    .out(out16), .busy(busy16)
`ifdef RAM_PARAM_PARITY_EN
    , .err_inject(err_inject), .parity_err(perr16)
`endif
  );

  ram_param #(.WIDTH(16), .ADDR_W(14), .DEPTH(12000)) u_dut12 (
    .clk(gclk), .reset(reset), .address(address), .load(load), .in(in),
    .out(out12), .busy(busy12)
`ifdef RAM_PARAM_PARITY_EN
    , .err_inject(err_inject), .parity_err(perr12)
`endif
  );

  typedef struct {
    string       tag;
    logic [15:0] e16;
    logic [15:0] e12;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m16 [16384];
  logic [15:0] m12 [12000];
  bit          busy_m;
  int          nerr = 0;
  int          nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) m16[i] = '0;
    for (int i = 0; i < 12000; i++) m12[i] = '0;
  endtask

  task automatic wr(input int a, input logic [15:0] d, input logic inj);
    @(negedge gclk);
    address = 14'(a); in = d; load = 1'b1; err_inject = inj;
    if (!busy_m) begin
      m16[a] = d;
      if (a < 12000) m12[a] = d;
    end
    @(negedge gclk);
    load = 1'b0; err_inject = 1'b0;
  endtask

  // Drive a read address, push expectations, then pop and compare.
  task automatic rd(input string tag, input int a);
    exp_t e;
    @(negedge gclk);
    address = 14'(a); load = 1'b0;
    e.tag = tag;
    e.e16 = busy_m ? 16'd0 : m16[a];
    e.e12 = (busy_m || a >= 12000) ? 16'd0 : m12[a];
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk({e.tag, "_d16"}, 32'(out16), 32'(e.e16));
    chk({e.tag, "_d12"}, 32'(out12), 32'(e.e12));
  endtask

  // Reset for one edge, release, and measure how long each busy stays high.
  // With probe set, a write to word 5 is held during the clear.
  task automatic reset_and_clear(input string tag, input bit probe);
    int c16, c12;
    @(negedge gclk);
    reset = 1'b1; busy_m = 1'b1;
    @(negedge gclk);
    chk({tag, "_rst_busy16"}, 32'(busy16), 32'd1);
    chk({tag, "_rst_busy12"}, 32'(busy12), 32'd1);
    chk({tag, "_rst_out16"}, 32'(out16), 32'd0);
`ifdef RAM_PARAM_PARITY_EN
    chk({tag, "_rst_perr16"}, 32'(perr16), 32'd0);
`endif
    reset = 1'b0;
    model_clear();
    if (probe) begin
      address = 14'd5; in = 16'd99; load = 1'b1;
    end
    #1;
    c16 = 0; c12 = 0;
    for (int i = 0; i < 20000; i++) begin
      if (busy16) c16++;
      if (busy12) c12++;
      if (!busy12) load = 1'b0;
      if (!busy16 && !busy12) break;
      @(negedge gclk);
    end
    load = 1'b0;
    busy_m = 1'b0;
    chk({tag, "_busy_cycles16"}, 32'(c16), 32'd16384);
    chk({tag, "_busy_cycles12"}, 32'(c12), 32'd12000);
  endtask

  initial begin
    reset = 1'b1; address = '0; load = 1'b0; in = '0; err_inject = 1'b0;
    busy_m = 1'b1;
    model_clear();
    @(negedge gclk);

    // Initial clear with a write attempt to word 5 held during busy.
    reset_and_clear("clr1", 1'b1);
    rd("clr1_a0", 0);
    rd("clr1_a4321", 4321);
    rd("clr1_a16383", 16383);
    rd("clr1_a5", 5);

    // Basic writes and reads back.
    wr(0, 16'd4321, 1'b0);
    rd("w0_a0", 0);
    rd("w0_a4321", 4321);
    wr(4321, 16'd12345, 1'b0);
    rd("w1_a12345", 12345);
    rd("w1_a4321", 4321);

    // Out of range for the 12000-word instance: no write, no aliasing.
    wr(12345, 16'd7, 1'b0);
    rd("oor_a12345", 12345);
    rd("oor_a57", 57);
    wr(11999, 16'hBEEF, 1'b0);
    rd("edge_a11999", 11999);

    // Reset at clr_cnt=100, then a full restart.
    @(negedge gclk);
    reset = 1'b1; busy_m = 1'b1;
    @(negedge gclk);
    reset = 1'b0;
    repeat (100) @(negedge gclk);
    chk("mid_busy16", 32'(busy16), 32'd1);
    rd("mid_out_gated", 0);
    reset_and_clear("clr2", 1'b0);
    rd("clr2_a0", 0);
    rd("clr2_a4321", 4321);
    rd("clr2_a12345", 12345);

`ifdef RAM_PARAM_PARITY_EN
    wr(7, 16'd1, 1'b1);
    @(posedge gclk); #1;
    chk("par_inj16", 32'(perr16), 32'd1);
    chk("par_inj12", 32'(perr12), 32'd1);
    rd("par_a0", 0);
    repeat (3) @(negedge gclk);
    chk("par_sticky16", 32'(perr16), 32'd1);
    reset_and_clear("clr3", 1'b0);
    wr(7, 16'd1, 1'b0);
    rd("par_ok_a7", 7);
    repeat (3) @(negedge gclk);
    chk("par_ok16", 32'(perr16), 32'd0);
    chk("par_ok12", 32'(perr12), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 14, address width in bits (1..16).
REQ-003 Parameter DEPTH, default 16384, number of words (1..2**ADDR_W; need not be a power of two).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port address  input  ADDR_W  read/write word address, unsigned.
REQ-007 Port load  input  1  write enable, sampled on rising edge.
REQ-008 Port in  input  WIDTH  write data.
REQ-009 Port out  output  WIDTH  read data.
REQ-010 Port busy  output  1  high while clear sequencer runs.
REQ-011 Port err_inject  input  1  parity-invert on write (present only with RAM_PARAM_PARITY_EN).
REQ-012 Port parity_err  output  1  sticky parity error flag (present only with RAM_PARAM_PARITY_EN).

Function
REQ-013 Read SHALL be combinational: out = mem[address] when busy=0 and address<DEPTH, else out = 0.
REQ-014 Write SHALL occur on the rising edge when load=1, busy=0, reset=0 and address<DEPTH; out shows new data in the same cycle after that edge.
REQ-015 load=1 with address>=DEPTH SHALL be ignored (no write, no wrap-around, no aliasing).
REQ-016 load=1 while busy=1 SHALL be ignored; no queuing.
REQ-017 Clear sequencer states: CLEAR and IDLE.
REQ-018 In CLEAR with reset=0, each edge SHALL write 0 to mem[clr_cnt] and increment clr_cnt.
REQ-019 CLEAR SHALL go to IDLE on the edge that writes mem[DEPTH-1]; busy SHALL be 0 from the next cycle onward.
REQ-020 After reset deasserts, busy SHALL stay high for exactly DEPTH cycles.
REQ-021 IDLE SHALL persist until reset; no other transition exists.
REQ-022 Inputs out-of-range or X during busy SHALL NOT affect the clear sequence.

Reset
REQ-023 While reset=1 on an edge: state<=CLEAR, clr_cnt<=0, busy=1, out=0, parity_err<=0 (if present).
REQ-024 Reset asserted mid-clear or in IDLE SHALL restart the clear from address 0 after deassertion.
REQ-025 Memory contents SHALL be undefined until the first full clear completes; no write occurs while reset=1.

Configuration
REQ-026 Macro RAM_PARAM_PARITY_EN SHALL compile in one even-parity bit per word, stored with every write (clear writes parity 0).
REQ-027 With the macro, a write with err_inject=1 SHALL store the inverted parity bit.
REQ-028 With the macro, parity_err SHALL set on the edge where busy=0, address<DEPTH and XOR of mem[address] and its parity bit is 1, and stay set until reset.
REQ-029 Without the macro, err_inject and parity_err ports and parity storage SHALL not exist; all other behaviour is identical.

Verification
REQ-030 Reset 1 cycle, release, run DEPTH cycles -> busy=1 for exactly 16384 cycles then 0; out=0 at addresses 0, 4321, 16383.
REQ-031 After clear, in=4321, load=1, address=0 for one edge; then load=0 -> out=4321 at address 0; out=0 at address 4321.
REQ-032 address=4321, in=12345, load=1 edge; address=12345, load=0 -> out=0; address=4321 -> out=12345.
REQ-033 With DEPTH=12000, load=1, address=12345, in=7 -> no write; out=0; mem[12345 mod 4096] unchanged.
REQ-034 load=1 during busy, address=5, in=99 -> after clear, out=0 at address 5; reset asserted at clr_cnt=100 -> busy lasts DEPTH more cycles after release.
REQ-035 (RAM_PARAM_PARITY_EN) write address=7, in=1, err_inject=1; read address 7 -> parity_err=1 after next edge, stays 1 until reset; same test with err_inject=0 -> parity_err=0.
